video_daisy_ctrl: RTL and testbench

//  Run-time controller for the video daisy chain. Owns core bypass bits and sprite anchors (x0/y0).

---
 rtl/video_ctrl_pkg.sv | 67 ++++++
 rtl/video_sprite_bouncer.sv | 57 +++++
 rtl/video_daisy_ctrl.sv | 171 +++++++++++++++++
 tb/tb_video_daisy_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/video_ctrl_pkg.sv
// Shared types and constants for the video daisy-chain run-time controller.
package video_ctrl_pkg;

   localparam int unsigned H_DISPLAY     = 640;
   localparam int unsigned V_DISPLAY     = 480;
   localparam int unsigned SPRITE_HSIZE  = 32;
   localparam int unsigned SPRITE_VSIZE  = 32;
   localparam int unsigned DWELL_DEFAULT = 120;

   localparam int unsigned H_SIZE = 10;
   localparam int unsigned V_SIZE = 10;
   localparam int unsigned CSR_AW = 3;
   localparam int unsigned CSR_DW = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BYP_W  = 4;

   localparam int unsigned PIKA_RST = 32;
   localparam int unsigned PAC_RST  = 64;

   localparam logic [CSR_AW-1:0] ADDR_CTRL   = 3'd0;
   localparam logic [CSR_AW-1:0] ADDR_DWELL  = 3'd1;
   localparam logic [CSR_AW-1:0] ADDR_PIKA   = 3'd2;
   localparam logic [CSR_AW-1:0] ADDR_PAC    = 3'd3;
   localparam logic [CSR_AW-1:0] ADDR_STATUS = 3'd4;

   localparam int unsigned CTRL_AUTO_BIT = 0;
   localparam int unsigned CTRL_MASK_LSB = 1;

   // Bypass bit order {gray, pacman, pikachu, bar}
   localparam logic [BYP_W-1:0] MASK_BAR  = 4'b1110;
   localparam logic [BYP_W-1:0] MASK_SPR1 = 4'b1100;
   localparam logic [BYP_W-1:0] MASK_SPR2 = 4'b1000;
   localparam logic [BYP_W-1:0] MASK_GRAY = 4'b0000;

   typedef enum logic [2:0] {
      ST_MANUAL = 3'd0,
      ST_BAR    = 3'd1,
      ST_SPR1   = 3'd2,
      ST_SPR2   = 3'd3,
      ST_GRAY   = 3'd4
   } state_e;

   typedef struct packed {
      logic [V_SIZE-1:0] y;
      logic [H_SIZE-1:0] x;
   } anchor_t;

   function automatic state_e next_auto(input state_e s);
      case (s)
         ST_BAR:  return ST_SPR1;
         ST_SPR1: return ST_SPR2;
         ST_SPR2: return ST_GRAY;
         default: return ST_BAR;
      endcase
   endfunction

   function automatic logic [BYP_W-1:0] auto_mask(input state_e s);
      case (s)
         ST_BAR:  return MASK_BAR;
         ST_SPR1: return MASK_SPR1;
         ST_SPR2: return MASK_SPR2;
         ST_GRAY: return MASK_GRAY;
         default: return MASK_GRAY;
      endcase
   endfunction

endpackage

// File: rtl/video_sprite_bouncer.sv
// One axis of a bouncing sprite anchor: position plus direction, reflecting at 0 and LIMIT.
module video_sprite_bouncer
   import video_ctrl_pkg::*;
#(
   parameter int unsigned W       = H_SIZE,
   parameter int unsigned LIMIT   = H_DISPLAY - SPRITE_HSIZE,
   parameter int unsigned RST_POS = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         step,
   output logic [W-1:0] pos
);

   logic [W-1:0] pos_q, pos_d;
   logic         dir_neg_q, dir_neg_d;

   // A load replaces the position but keeps the current direction
   always_comb begin
      pos_d     = pos_q;
      dir_neg_d = dir_neg_q;
      if (load) begin
         pos_d = load_val;
      end else if (step) begin
         if (!dir_neg_q) begin
            if (pos_q >= W'(LIMIT)) begin
               dir_neg_d = 1'b1;
               pos_d     = pos_q - W'(1);
            end else begin
               pos_d = pos_q + W'(1);
            end
         end else begin
            if (pos_q == '0) begin
               dir_neg_d = 1'b0;
               pos_d     = pos_q + W'(1);
            end else begin
               pos_d = pos_q - W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q     <= W'(RST_POS);
         dir_neg_q <= 1'b0;
      end else begin
         pos_q     <= pos_d;
         dir_neg_q <= dir_neg_d;
      end
   end

   assign pos = pos_q;

endmodule

// File: rtl/video_daisy_ctrl.sv
// Run-time controller for the video daisy chain: CSR shadows committed on unstalled frame_start.
// Optional feature: VIDEO_DAISY_CTRL_BOUNCE_EN makes the pikachu anchor bounce around the screen.
module video_daisy_ctrl
   import video_ctrl_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              stall,
   input  logic              frame_start,
   input  logic              csr_we,
   input  logic              csr_rd,
   input  logic [CSR_AW-1:0] csr_addr,
   input  logic [CSR_DW-1:0] csr_wdata,
   output logic [CSR_DW-1:0] csr_rdata,
   output logic              bar_core_bypass,
   output logic              pikachu_core_bypass,
   output logic              pacman_core_bypass,
   output logic              rgb2gray_core_bypass,
   output logic [H_SIZE-1:0] pikachu_x0,
   output logic [V_SIZE-1:0] pikachu_y0,
   output logic [H_SIZE-1:0] pacman_x0,
   output logic [V_SIZE-1:0] pacman_y0
);

   logic commit, wr_ctrl, wr_dwell, wr_pika, wr_pac;
   assign commit   = frame_start & ~stall;
   assign wr_ctrl  = csr_we && (csr_addr == ADDR_CTRL);
   assign wr_dwell = csr_we && (csr_addr == ADDR_DWELL);
   assign wr_pika  = csr_we && (csr_addr == ADDR_PIKA);
   assign wr_pac   = csr_we && (csr_addr == ADDR_PAC);

   anchor_t pika_shadow;

`ifdef VIDEO_DAISY_CTRL_BOUNCE_EN
   logic [H_SIZE-1:0] bounce_x;
   logic [V_SIZE-1:0] bounce_y;

   video_sprite_bouncer #(.W(H_SIZE), .LIMIT(H_DISPLAY - SPRITE_HSIZE), .RST_POS(PIKA_RST)) u_bounce_x (
      .clk(sys_clk), .rst(sys_rst), .load(wr_pika), .load_val(csr_wdata[H_SIZE-1:0]),
      .step(commit), .pos(bounce_x));

   video_sprite_bouncer #(.W(V_SIZE), .LIMIT(V_DISPLAY - SPRITE_VSIZE), .RST_POS(PIKA_RST)) u_bounce_y (
      .clk(sys_clk), .rst(sys_rst), .load(wr_pika), .load_val(csr_wdata[16 +: V_SIZE]),
      .step(commit), .pos(bounce_y));

   assign pika_shadow = '{y: bounce_y, x: bounce_x};
`else
   anchor_t pika_q, pika_d;

   always_comb begin
      pika_d = pika_q;
      if (wr_pika) pika_d = '{y: csr_wdata[16 +: V_SIZE], x: csr_wdata[H_SIZE-1:0]};
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) pika_q <= '{y: V_SIZE'(PIKA_RST), x: H_SIZE'(PIKA_RST)};
      else         pika_q <= pika_d;
   end

   assign pika_shadow = pika_q;
`endif

   logic              auto_en_q, auto_en_d;
   logic [BYP_W-1:0]  mask_q, mask_d, bypass_q, bypass_d;
   logic [CNT_W-1:0]  dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d, frame_cnt_q, frame_cnt_d;
   anchor_t           pac_q, pac_d, pika_out_q, pika_out_d, pac_out_q, pac_out_d;
   state_e            state_q, state_d;
   logic [CSR_DW-1:0] rdata_q, rdata_d;
   logic              dwell_last;

   // A DWELL of 0 behaves like 1: every commit advances
   assign dwell_last = (dwell_q == '0) || (dwell_cnt_q >= dwell_q - CNT_W'(1));

   always_comb begin
      auto_en_d   = auto_en_q;
      mask_d      = mask_q;
      dwell_d     = dwell_q;
      pac_d       = pac_q;
      bypass_d    = bypass_q;
      pika_out_d  = pika_out_q;
      pac_out_d   = pac_out_q;
      state_d     = state_q;
      dwell_cnt_d = dwell_cnt_q;
      frame_cnt_d = frame_cnt_q;
      rdata_d     = rdata_q;

      if (wr_ctrl) begin
         auto_en_d = csr_wdata[CTRL_AUTO_BIT];
         mask_d    = csr_wdata[CTRL_MASK_LSB +: BYP_W];
      end
      if (wr_dwell) dwell_d = csr_wdata[CNT_W-1:0];
      if (wr_pac)   pac_d   = '{y: csr_wdata[16 +: V_SIZE], x: csr_wdata[H_SIZE-1:0]};

      // Commit uses the shadow contents from before this edge
      if (commit) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
         pika_out_d  = pika_shadow;
         pac_out_d   = pac_q;
         if (!auto_en_q) begin
            state_d     = ST_MANUAL;
            bypass_d    = mask_q;
            dwell_cnt_d = '0;
         end else if (state_q == ST_MANUAL) begin
            state_d     = ST_BAR;
            bypass_d    = MASK_BAR;
            dwell_cnt_d = '0;
         end else if (dwell_last) begin
            state_d     = next_auto(state_q);
            bypass_d    = auto_mask(next_auto(state_q));
            dwell_cnt_d = '0;
         end else begin
            bypass_d    = auto_mask(state_q);
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
         end
      end
      if (wr_dwell) dwell_cnt_d = '0;

      if (csr_rd) begin
         case (csr_addr)
            ADDR_CTRL:   rdata_d = {27'd0, mask_q, auto_en_q};
            ADDR_DWELL:  rdata_d = {16'd0, dwell_q};
            ADDR_PIKA:   rdata_d = {6'd0, pika_shadow.y, 6'd0, pika_shadow.x};
            ADDR_PAC:    rdata_d = {6'd0, pac_q.y, 6'd0, pac_q.x};
            ADDR_STATUS: rdata_d = {frame_cnt_q, 13'd0, state_q};
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         auto_en_q   <= 1'b0;
         mask_q      <= '0;
         dwell_q     <= CNT_W'(DWELL_DEFAULT);
         pac_q       <= '{y: V_SIZE'(PAC_RST), x: H_SIZE'(PAC_RST)};
         bypass_q    <= '0;
         pika_out_q  <= '{y: V_SIZE'(PIKA_RST), x: H_SIZE'(PIKA_RST)};
         pac_out_q   <= '{y: V_SIZE'(PAC_RST), x: H_SIZE'(PAC_RST)};
         state_q     <= ST_MANUAL;
         dwell_cnt_q <= '0;
         frame_cnt_q <= '0;
         rdata_q     <= '0;
      end else begin
         auto_en_q   <= auto_en_d;
         mask_q      <= mask_d;
         dwell_q     <= dwell_d;
         pac_q       <= pac_d;
         bypass_q    <= bypass_d;
         pika_out_q  <= pika_out_d;
         pac_out_q   <= pac_out_d;
         state_q     <= state_d;
         dwell_cnt_q <= dwell_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         rdata_q     <= rdata_d;
      end
   end

   logic unused_wdata;
   assign unused_wdata = ^csr_wdata[31:26];

   assign csr_rdata            = rdata_q;
   assign bar_core_bypass      = bypass_q[0];
   assign pikachu_core_bypass  = bypass_q[1];
   assign pacman_core_bypass   = bypass_q[2];
   assign rgb2gray_core_bypass = bypass_q[3];
   assign pikachu_x0           = pika_out_q.x;
   assign pikachu_y0           = pika_out_q.y;
   assign pacman_x0            = pac_out_q.x;
   assign pacman_y0            = pac_out_q.y;

endmodule

// File: tb/tb_video_daisy_ctrl.sv
// Bench for video_daisy_ctrl: table-driven cycles with a scoreboard queue, plus an async-reset sequence.
module tb_video_daisy_ctrl;
   import video_ctrl_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst, stall, frame_start, csr_we, csr_rd;
   logic [2:0]  csr_addr;
   logic [31:0] csr_wdata, csr_rdata;
   logic        bar_b, pika_b, pac_b, gray_b;
   logic [9:0]  pika_x, pika_y, pac_x, pac_y;
   logic [3:0]  byp_got;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        we, rd;
      logic [2:0]  addr;
      logic [31:0] wd;
      logic        fs, st;
      logic [3:0]  byp;
      logic [9:0]  px, py, qx, qy;
      logic        chk_pk, chk_rd;
      logic [31:0] rdv;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];
   vec_t e_chk;

`ifdef VIDEO_DAISY_CTRL_BOUNCE_EN
   localparam logic [3:0]  END_BYP = 4'b0000;
   localparam int          END_QX = 64, END_QY = 64;
   localparam logic [15:0] T6_FRAMES = 16'd7;
`else
   localparam logic [3:0]  END_BYP = 4'b0101;
   localparam int          END_QX = 200, END_QY = 100;
   localparam logic [15:0] T6_FRAMES = 16'd22;
`endif

   video_daisy_ctrl dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .stall(stall), .frame_start(frame_start),
      .csr_we(csr_we), .csr_rd(csr_rd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata),
      .bar_core_bypass(bar_b), .pikachu_core_bypass(pika_b),
      .pacman_core_bypass(pac_b), .rgb2gray_core_bypass(gray_b),
      .pikachu_x0(pika_x), .pikachu_y0(pika_y), .pacman_x0(pac_x), .pacman_y0(pac_y));

   assign byp_got = {gray_b, pac_b, pika_b, bar_b};

   always #5 sys_clk = ~sys_clk;

   function automatic vec_t mk(input string n, input logic we, input logic rd, input logic [2:0] a,
                               input logic [31:0] wd, input logic fs, input logic st, input logic [3:0] byp,
                               input int px, input int py, input int qx, input int qy,
                               input logic chk_rd, input logic [31:0] rdv);
      vec_t v;
      v.name = n; v.we = we; v.rd = rd; v.addr = a; v.wd = wd; v.fs = fs; v.st = st;
      v.byp = byp; v.px = 10'(px); v.py = 10'(py); v.qx = 10'(qx); v.qy = 10'(qy);
      v.chk_pk = 1'b1; v.chk_rd = chk_rd; v.rdv = rdv;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      csr_we = v.we; csr_rd = v.rd; csr_addr = v.addr; csr_wdata = v.wd;
      frame_start = v.fs; stall = v.st;
      @(posedge sys_clk);
      #1;
      exp_q.push_back(v);
      csr_we = 1'b0; csr_rd = 1'b0; frame_start = 1'b0; stall = 1'b0;
   endtask

   // Scoreboard: each applied cycle's expectation is checked on the following falling edge
   always @(negedge sys_clk) begin
      if (exp_q.size() > 0) begin
         e_chk = exp_q.pop_front();
         checks++;
         if (e_chk.chk_pk ? ({byp_got, pika_x, pika_y, pac_x, pac_y} !== {e_chk.byp, e_chk.px, e_chk.py, e_chk.qx, e_chk.qy})
                          : ({byp_got, pac_x, pac_y} !== {e_chk.byp, e_chk.qx, e_chk.qy})) begin
            errors++;
            $display("FAIL %s outputs: got byp=%b pika=(%0d,%0d) pac=(%0d,%0d) want byp=%b pika=(%0d,%0d) pac=(%0d,%0d)",
                     e_chk.name, byp_got, pika_x, pika_y, pac_x, pac_y,
                     e_chk.byp, e_chk.px, e_chk.py, e_chk.qx, e_chk.qy);
         end
         if (e_chk.chk_rd) begin
            checks++;
            if (csr_rdata !== e_chk.rdv) begin
               errors++;
               $display("FAIL %s rdata: got %h want %h", e_chk.name, csr_rdata, e_chk.rdv);
            end
         end
      end
   end

   initial begin
      vec_t h;
      sys_rst = 1'b1; stall = 1'b0; frame_start = 1'b0; csr_we = 1'b0; csr_rd = 1'b0;
      csr_addr = '0; csr_wdata = '0;

`ifdef VIDEO_DAISY_CTRL_BOUNCE_EN
      tbl.push_back(mk("bnc_wr",    1, 0, ADDR_PIKA, 32'h01BF_025F, 0, 0, 4'b0000, 32, 32, 64, 64, 0, 0));
      tbl.push_back(mk("bnc_c1",    0, 0, 3'd0, 0, 1, 0, 4'b0000, 607, 447, 64, 64, 0, 0));
      tbl.push_back(mk("bnc_limit", 0, 0, 3'd0, 0, 1, 0, 4'b0000, 608, 448, 64, 64, 0, 0));
      tbl.push_back(mk("bnc_flip",  0, 0, 3'd0, 0, 1, 0, 4'b0000, 607, 447, 64, 64, 0, 0));
      tbl.push_back(mk("bnc_rd",    0, 1, ADDR_PIKA, 0, 0, 0, 4'b0000, 607, 447, 64, 64, 1, 32'h01BE_025E));
      tbl.push_back(mk("bnc_down",  0, 0, 3'd0, 0, 1, 0, 4'b0000, 606, 446, 64, 64, 0, 0));
`else
      tbl.push_back(mk("pika_wr",     1, 0, ADDR_PIKA, 32'h0032_0064, 0, 0, 4'b0000, 32, 32, 64, 64, 0, 0));
      tbl.push_back(mk("idle",        0, 0, 3'd0, 0, 0, 0, 4'b0000, 32, 32, 64, 64, 0, 0));
      tbl.push_back(mk("stall_fs",    0, 0, 3'd0, 0, 1, 1, 4'b0000, 32, 32, 64, 64, 0, 0));
      tbl.push_back(mk("status0",     0, 1, ADDR_STATUS, 0, 0, 0, 4'b0000, 32, 32, 64, 64, 1, 32'h0000_0000));
      tbl.push_back(mk("commit1",     0, 0, 3'd0, 0, 1, 0, 4'b0000, 100, 50, 64, 64, 0, 0));
      tbl.push_back(mk("status1",     0, 1, ADDR_STATUS, 0, 0, 0, 4'b0000, 100, 50, 64, 64, 1, 32'h0001_0000));
      tbl.push_back(mk("stall_fs2",   0, 0, 3'd0, 0, 1, 1, 4'b0000, 100, 50, 64, 64, 0, 0));
      tbl.push_back(mk("status1b",    0, 1, ADDR_STATUS, 0, 0, 0, 4'b0000, 100, 50, 64, 64, 1, 32'h0001_0000));
      tbl.push_back(mk("wr_fs_same",  1, 0, ADDR_PAC, 32'h0064_00C8, 1, 0, 4'b0000, 100, 50, 64, 64, 0, 0));
      tbl.push_back(mk("pac_rd",      0, 1, ADDR_PAC, 0, 0, 0, 4'b0000, 100, 50, 64, 64, 1, 32'h0064_00C8));
      tbl.push_back(mk("pac_commit",  0, 0, 3'd0, 0, 1, 0, 4'b0000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("ctrl_wr",     1, 0, ADDR_CTRL, 32'h0000_000A, 0, 0, 4'b0000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("mask_commit", 0, 0, 3'd0, 0, 1, 0, 4'b0101, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("ctrl_rd",     0, 1, ADDR_CTRL, 0, 0, 0, 4'b0101, 100, 50, 200, 100, 1, 32'h0000_000A));
      tbl.push_back(mk("bad_wr",      1, 0, 3'd6, 32'hFFFF_FFFF, 0, 0, 4'b0101, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("bad_rd",      0, 1, 3'd6, 0, 0, 0, 4'b0101, 100, 50, 200, 100, 1, 32'h0000_0000));
      tbl.push_back(mk("ctrl_rd2",    0, 1, ADDR_CTRL, 0, 0, 0, 4'b0101, 100, 50, 200, 100, 1, 32'h0000_000A));
      tbl.push_back(mk("dwell_wr",    1, 0, ADDR_DWELL, 32'd2, 0, 0, 4'b0101, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_on",     1, 0, ADDR_CTRL, 32'd1, 0, 0, 4'b0101, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c1",     0, 0, 3'd0, 0, 1, 0, 4'b1110, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c2",     0, 0, 3'd0, 0, 1, 0, 4'b1110, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c3",     0, 0, 3'd0, 0, 1, 0, 4'b1100, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("status_spr1", 0, 1, ADDR_STATUS, 0, 0, 0, 4'b1100, 100, 50, 200, 100, 1, 32'h0007_0002));
      tbl.push_back(mk("auto_c4",     0, 0, 3'd0, 0, 1, 0, 4'b1100, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c5",     0, 0, 3'd0, 0, 1, 0, 4'b1000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c6",     0, 0, 3'd0, 0, 1, 0, 4'b1000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c7",     0, 0, 3'd0, 0, 1, 0, 4'b0000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c8",     0, 0, 3'd0, 0, 1, 0, 4'b0000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c9",     0, 0, 3'd0, 0, 1, 0, 4'b1110, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_c10",    0, 0, 3'd0, 0, 1, 0, 4'b1110, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("dwell_clr",   1, 0, ADDR_DWELL, 32'd2, 0, 0, 4'b1110, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("after_clr1",  0, 0, 3'd0, 0, 1, 0, 4'b1110, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("after_clr2",  0, 0, 3'd0, 0, 1, 0, 4'b1100, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("dwell_zero",  1, 0, ADDR_DWELL, 32'd0, 0, 0, 4'b1100, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("dwell_rd",    0, 1, ADDR_DWELL, 0, 0, 0, 4'b1100, 100, 50, 200, 100, 1, 32'h0000_0000));
      tbl.push_back(mk("dz_c1",       0, 0, 3'd0, 0, 1, 0, 4'b1000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("dz_c2",       0, 0, 3'd0, 0, 1, 0, 4'b0000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("auto_off",    1, 0, ADDR_CTRL, 32'h0000_000A, 0, 0, 4'b0000, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("manual_back", 0, 0, 3'd0, 0, 1, 0, 4'b0101, 100, 50, 200, 100, 0, 0));
      tbl.push_back(mk("status_man",  0, 1, ADDR_STATUS, 0, 0, 0, 4'b0101, 100, 50, 200, 100, 1, 32'h0013_0000));
      tbl.push_back(mk("rdata_hold",  0, 0, 3'd0, 0, 0, 0, 4'b0101, 100, 50, 200, 100, 1, 32'h0013_0000));
`endif

      repeat (3) @(posedge sys_clk);
      #1;
      checks++;
      if ({byp_got, pika_x, pika_y, pac_x, pac_y, csr_rdata} !==
          {4'b0000, 10'd32, 10'd32, 10'd64, 10'd64, 32'd0}) begin
         errors++;
         $display("FAIL reset_state: got byp=%b pika=(%0d,%0d) pac=(%0d,%0d) rdata=%h want 0000/(32,32)/(64,64)/0",
                  byp_got, pika_x, pika_y, pac_x, pac_y, csr_rdata);
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;

      foreach (tbl[i]) apply(tbl[i]);

      // Run auto mode up to SPR2, then hit reset between clock edges
      h = mk("t6_dwell", 1, 0, ADDR_DWELL, 32'd1, 0, 0, END_BYP, 0, 0, END_QX, END_QY, 0, 0);
      h.chk_pk = 1'b0; apply(h);
      h = mk("t6_auto", 1, 0, ADDR_CTRL, 32'd1, 0, 0, END_BYP, 0, 0, END_QX, END_QY, 0, 0);
      h.chk_pk = 1'b0; apply(h);
      h = mk("t6_bar", 0, 0, 3'd0, 0, 1, 0, 4'b1110, 0, 0, END_QX, END_QY, 0, 0);
      h.chk_pk = 1'b0; apply(h);
      h = mk("t6_spr1", 0, 0, 3'd0, 0, 1, 0, 4'b1100, 0, 0, END_QX, END_QY, 0, 0);
      h.chk_pk = 1'b0; apply(h);
      h = mk("t6_spr2", 0, 0, 3'd0, 0, 1, 0, 4'b1000, 0, 0, END_QX, END_QY, 0, 0);
      h.chk_pk = 1'b0; apply(h);
      h = mk("t6_status", 0, 1, ADDR_STATUS, 0, 0, 0, 4'b1000, 0, 0, END_QX, END_QY, 1, {T6_FRAMES, 16'h0003});
      h.chk_pk = 1'b0; apply(h);

      @(negedge sys_clk);
      #2;
      sys_rst = 1'b1;
      #1;
      checks++;
      if ({byp_got, pika_x, pika_y, pac_x, pac_y, csr_rdata} !==
          {4'b0000, 10'd32, 10'd32, 10'd64, 10'd64, 32'd0}) begin
         errors++;
         $display("FAIL async_reset: got byp=%b pika=(%0d,%0d) pac=(%0d,%0d) rdata=%h want 0000/(32,32)/(64,64)/0",
                  byp_got, pika_x, pika_y, pac_x, pac_y, csr_rdata);
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;

      apply(mk("rst_status", 0, 1, ADDR_STATUS, 0, 0, 0, 4'b0000, 32, 32, 64, 64, 1, 32'h0000_0000));
      apply(mk("rst_dwell",  0, 1, ADDR_DWELL, 0, 0, 0, 4'b0000, 32, 32, 64, 64, 1, 32'h0000_0078));
      apply(mk("rst_pika",   0, 1, ADDR_PIKA, 0, 0, 0, 4'b0000, 32, 32, 64, 64, 1, 32'h0020_0020));
      apply(mk("rst_commit", 0, 0, 3'd0, 0, 1, 0, 4'b0000, 32, 32, 64, 64, 0, 0));

      repeat (2) @(negedge sys_clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
